// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the NPC core.
// Holds the PC and keeps at most one 32-bit fetch outstanding on a valid/ready
// memory port. The fetched word is presented to decode through a valid/ready
// handshake. Redirects restart fetch at a new PC, and the single kill bit drops
// any stale in-flight response.
//
// Optional build macro IFU_ALIGN_CHK_EN: when defined, a fetch from an address
// with addr[1:0] != 0 issues no memory request. Instead it is delivered
// directly as a nop with the fault flag set. When undefined, pc[1:0] goes to
// memory unchanged.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_err
);

`ifdef IFU_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic        kill_r;
  logic        mem_req_valid_r;
  logic        out_valid_r;
  logic [31:0] out_inst_r;
  logic [31:0] out_pc_r;
  logic        out_err_r;
  logic        req_hs_s;
  logic [31:0] pc_inc_s;

  // A fetch address may go to memory unless the alignment check rejects it.
  function automatic logic req_ok(input logic [31:0] addr);
    return (!ALIGN_CHK) || (addr[1:0] == 2'b00);
  endfunction

  assign req_hs_s      = mem_req_valid_r & mem_req_ready;
  assign pc_inc_s      = pc_r + PC_STEP;

  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_addr  = pc_r;
  assign out_valid     = out_valid_r;
  assign out_inst      = out_inst_r;
  assign out_pc        = out_pc_r;
  assign out_err       = out_err_r;

  // Fetch FSM: PC, kill bit and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      pc_r            <= RESET_PC;
      kill_r          <= 1'b0;
      mem_req_valid_r <= 1'b0;
      out_valid_r     <= 1'b0;
      out_inst_r      <= 32'h0000_0000;
      out_pc_r        <= RESET_PC;
      out_err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_REQ;
          if (redirect_valid) begin
            pc_r            <= redirect_pc;
            mem_req_valid_r <= req_ok(redirect_pc);
          end else begin
            mem_req_valid_r <= req_ok(pc_r);
          end
        end

        ST_REQ: begin
          if (redirect_valid) begin
            pc_r <= redirect_pc;
            if (req_hs_s) begin
              // The old address was already accepted, so its response is stale.
              state_r         <= ST_WAIT;
              kill_r          <= 1'b1;
              mem_req_valid_r <= 1'b0;
            end else begin
              state_r         <= ST_REQ;
              mem_req_valid_r <= req_ok(redirect_pc);
            end
          end else if (req_hs_s) begin
            state_r         <= ST_WAIT;
            kill_r          <= 1'b0;
            mem_req_valid_r <= 1'b0;
          end else if (!mem_req_valid_r) begin
            // Misaligned fetch: deliver a faulting nop without touching memory.
            state_r     <= ST_OUT;
            out_valid_r <= 1'b1;
            out_inst_r  <= NOP_INST;
            out_pc_r    <= pc_r;
            out_err_r   <= 1'b1;
          end else begin
            state_r <= ST_REQ;
          end
        end

        ST_WAIT: begin
          if (mem_rsp_valid) begin
            if (redirect_valid) begin
              pc_r            <= redirect_pc;
              kill_r          <= 1'b0;
              state_r         <= ST_REQ;
              mem_req_valid_r <= req_ok(redirect_pc);
            end else if (kill_r) begin
              kill_r          <= 1'b0;
              state_r         <= ST_REQ;
              mem_req_valid_r <= req_ok(pc_r);
            end else begin
              out_valid_r <= 1'b1;
              out_inst_r  <= mem_rsp_data;
              out_pc_r    <= pc_r;
              out_err_r   <= mem_rsp_err;
              state_r     <= ST_OUT;
            end
          end else if (redirect_valid) begin
            pc_r   <= redirect_pc;
            kill_r <= 1'b1;
          end else begin
            kill_r <= kill_r;
          end
        end

        ST_OUT: begin
          if (redirect_valid) begin
            // Redirect wins over a same-cycle decode handshake.
            pc_r            <= redirect_pc;
            out_valid_r     <= 1'b0;
            state_r         <= ST_REQ;
            mem_req_valid_r <= req_ok(redirect_pc);
          end else if (out_ready) begin
            pc_r            <= pc_inc_s;
            out_valid_r     <= 1'b0;
            state_r         <= ST_REQ;
            mem_req_valid_r <= req_ok(pc_inc_s);
          end else begin
            out_valid_r <= 1'b1;
          end
        end

        default: begin
          state_r         <= ST_IDLE;
          mem_req_valid_r <= 1'b0;
          out_valid_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized scoreboard bench for ifu_fetch.
// The reference model tracks the architectural fetch stream: the expected PC
// advances by 4 on each accepted instruction and jumps on every redirect. A
// response becomes an expected delivery only if no redirect happened between
// its acceptance and its arrival.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_err;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_err(out_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } item_t;

  item_t       sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] salt;

  // stimulus knobs and memory responder state
  int          p_ready, maxd, p_oready, p_redir, p_err;
  bit          hold_rsp, ideal_phase;
  bit          pending, req_stale;
  int          dcnt;
  int unsigned epoch, req_epoch;
  logic [31:0] req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ salt;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0:       t = 32'h8000_0100;
      1:       t = 32'h8000_0200;
      2:       t = 32'hFFFF_FFF8;
      default: t = $urandom & 32'hFFFF_FFFC;
    endcase
    return t;
  endfunction

  // record an accepted request (called mid-cycle, when everything is stable)
  task automatic drv_sample();
    if (mem_req_valid && mem_req_ready) begin
      pending   = 1'b1;
      req_addr  = mem_req_addr;
      req_epoch = epoch;
      req_stale = redirect_valid;
      dcnt      = $urandom_range(0, maxd);
    end
  endtask

  // drive the inputs for the coming cycle
  task automatic drv_drive();
    bit    stale;
    item_t it;
    redirect_valid = (int'($urandom_range(0, 99)) < p_redir);
    redirect_pc    = pick_target();
    if (redirect_valid) epoch++;
    mem_req_ready  = (int'($urandom_range(0, 99)) < p_ready);
    out_ready      = (int'($urandom_range(0, 99)) < p_oready);
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = $urandom;
    mem_rsp_err    = 1'($urandom);
    if (pending && !hold_rsp) begin
      if (dcnt == 0) begin
        stale         = req_stale || (req_epoch != epoch);
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = (int'($urandom_range(0, 99)) < p_err);
        mem_rsp_data  = stale ? 32'hDEAD_BEEF : mem_word(req_addr);
        if (!stale) begin
          it.pc   = req_addr;
          it.inst = mem_rsp_data;
          it.err  = mem_rsp_err;
          sb_q.push_back(it);
        end
        pending = 1'b0;
      end else begin
        dcnt--;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drv_sample();
    @(posedge clk);
    #1;
    drv_drive();
  endtask

  task automatic set_knobs(input int r, input int d, input int o, input int rd, input int e);
    p_ready = r; maxd = d; p_oready = o; p_redir = rd; p_err = e;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    chk({pfx, "_req_addr"},  mem_req_addr,           RESET_PC);
    chk({pfx, "_out_valid"}, {31'd0, out_valid},     32'd0);
    chk({pfx, "_out_inst"},  out_inst,               32'd0);
    chk({pfx, "_out_pc"},    out_pc,                 RESET_PC);
    chk({pfx, "_out_err"},   {31'd0, out_err},       32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] model_pc;
  bit          exp_hold, exp_drop, last_ideal;
  logic [31:0] h_inst, h_pc;
  logic        h_err;
  int          cyc = 0, last_deliv = 0, idle_cnt = 0, n_deliv = 0;
  item_t       mon_it;

  always @(negedge clk) begin
    if (rst) begin
      model_pc   = RESET_PC;
      sb_q.delete();
      exp_hold   = 1'b0;
      exp_drop   = 1'b0;
      last_ideal = 1'b0;
      idle_cnt   = 0;
    end else begin
      cyc++;
      idle_cnt++;
      if (exp_hold) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_inst",  out_inst, h_inst);
        chk("hold_pc",    out_pc,   h_pc);
        chk("hold_err",   {31'd0, out_err}, {31'd0, h_err});
      end
      if (exp_drop) chk("redirect_drop", {31'd0, out_valid}, 32'd0);
      exp_hold = 1'b0;
      exp_drop = 1'b0;
      if (mem_req_valid && mem_req_ready) chk("req_addr", mem_req_addr, model_pc);
      if (out_valid) begin
        chk("req_while_out", {31'd0, mem_req_valid}, 32'd0);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_out: out_valid=1 inst %h pc %h, required no instruction", out_inst, out_pc);
        end else if (redirect_valid) begin
          void'(sb_q.pop_front());
          exp_drop = 1'b1;
          idle_cnt = 0;
        end else if (out_ready) begin
          mon_it = sb_q.pop_front();
          chk("out_inst", out_inst, mon_it.inst);
          chk("out_pc", out_pc, mon_it.pc);
          chk("out_pc_stream", out_pc, model_pc);
          chk("out_err", {31'd0, out_err}, {31'd0, mon_it.err});
          n_deliv++;
          idle_cnt = 0;
          if (ideal_phase) begin
            if (last_ideal) chk("ideal_gap", cyc - last_deliv, 32'd3);
            last_ideal = 1'b1;
            last_deliv = cyc;
          end else begin
            last_ideal = 1'b0;
          end
        end else begin
          exp_hold = 1'b1;
          h_inst   = out_inst;
          h_pc     = out_pc;
          h_err    = out_err;
        end
      end
      if (redirect_valid) model_pc = redirect_pc;
      else if (out_valid && out_ready) model_pc = model_pc + 32'd4;
      if (idle_cnt > 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL progress: %0d cycles without delivery, required <= 300", idle_cnt);
        idle_cnt = 0;
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    salt           = $urandom;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'd0;
    mem_rsp_err    = 1'b0;
    out_ready      = 1'b0;
    epoch          = 0;
    pending        = 1'b0;
    req_stale      = 1'b0;
    hold_rsp       = 1'b0;
    ideal_phase    = 1'b0;
    dcnt           = 0;
    req_epoch      = 0;
    req_addr       = 32'd0;
    set_knobs(100, 0, 100, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    // ideal flow: one instruction every 3 cycles
    ideal_phase = 1'b1;
    rst = 1'b0;
    drv_drive();
    repeat (30) cycle();

    // decode back-pressure
    ideal_phase = 1'b0;
    set_knobs(100, 0, 30, 0, 10);
    repeat (80) cycle();

    // general random traffic
    set_knobs(70, 3, 70, 8, 12);
    repeat (2500) cycle();

    // redirect storm
    set_knobs(70, 2, 60, 40, 12);
    repeat (500) cycle();

    // asynchronous reset while a fetch is outstanding
    set_knobs(100, 0, 100, 0, 0);
    hold_rsp = 1'b1;
    begin
      int k = 0;
      while (!pending && k < 40) begin
        cycle();
        k++;
      end
    end
    chk("reach_wait", {31'd0, pending}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("arst");
    pending        = 1'b0;
    hold_rsp       = 1'b0;
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    ideal_phase = 1'b1;
    rst = 1'b0;
    drv_drive();
    repeat (20) cycle();
    ideal_phase = 1'b0;

    chk("enough_deliveries", {31'd0, n_deliv >= 100}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
